alu_wb_buffer: RTL
==================

Name: alu_wb_buffer

Overview:
- Result buffer directly downstream of the ALU in the fixed-latency functional-unit path.
- Captures each ALU result and its transaction ID and holds them in a small FIFO until the shared writeback port accepts them.
- The ALU itself stays purely combinational; this block absorbs writeback-port stalls, for example when multiplier or CSR results win arbitration.
- The output is registered, so the path from the ALU adder/shifter to the scoreboard is cut.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration. XLEN comes from riscv::XLEN.
- DEPTH, 2: number of buffer entries. Must be a power of two and at least 2.
- TRANS_ID_BITS, ariane_pkg::TRANS_ID_BITS: width of the scoreboard transaction ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush. Discards all buffered entries.
- alu_valid_i  in  1  ALU result valid this cycle.
- alu_ready_o  out  1  buffer can accept a result this cycle.
- alu_result_i  in  XLEN  result_o from the ALU.
- alu_trans_id_i  in  TRANS_ID_BITS  scoreboard ID of the instruction.
- wb_valid_o  out  1  head entry valid toward writeback.
- wb_ready_i  in  1  writeback port accepts the head entry.
- wb_result_o  out  XLEN  head result.
- wb_trans_id_o  out  TRANS_ID_BITS  head transaction ID.
- count_o  out  $clog2(DEPTH)+1  current occupancy (0..DEPTH).

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - count, read pointer and write pointer = 0.
  - wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0, alu_ready_o=1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately; nothing is written back afterwards.
- Push: occurs when alu_valid_i && alu_ready_o. The entry is written at the write pointer on the clock edge, and the write pointer increments modulo DEPTH.
- Pop: occurs when wb_valid_o && wb_ready_i. The read pointer increments modulo DEPTH.
- Latency:
  - A result pushed into an empty buffer appears on wb_valid_o/wb_result_o in the next cycle. Minimum latency is 1; there is no same-cycle bypass.
  - Order is strict FIFO.
- Outputs:
  - alu_ready_o = (count < DEPTH). It is a function of registered state only, with no combinational path from wb_ready_i.
  - wb_valid_o = (count != 0).
  - wb_result_o and wb_trans_id_o come from the head entry and are driven from registers.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, and both pointers advance.
- Full (count==DEPTH): alu_ready_o=0 even if wb_ready_i=1 in the same cycle. A pop while full frees the slot for the next cycle.
- Empty (count==0): wb_valid_o=0, and wb_ready_i is ignored.
- Stall: while wb_valid_o && !wb_ready_i, the wb_* outputs must remain stable cycle to cycle.
- Flush:
  - flush_i=1 takes priority over push and pop in the same cycle.
  - Next cycle: count=0, both pointers=0, wb_valid_o=0.
  - A push coinciding with the flush is discarded.
  - The wb_ready_i pop in the flush cycle has no architectural effect; the scoreboard ignores it.
- Protocol error:
  - alu_valid_i=1 while alu_ready_o=0 is an upstream error. The result is dropped and state is unchanged.
  - A simulation-only assertion flags it.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No pop when empty.
  - wb_* outputs stable under stall.
  - DEPTH is a power of two and at least 2 (elaboration check).

Test Plan:
- Reset release, then push result 0xDEAD_BEEF with trans_id 3 while wb_ready_i=1 → wb_valid_o=1 one cycle later carrying 0xDEAD_BEEF and ID 3; popped that cycle; count returns to 0.
- Hold wb_ready_i=0 and push A(id1), B(id2) → count=2, alu_ready_o=0, head stays A stable for 5 cycles. Then raise wb_ready_i → A and B emerge on consecutive cycles, in order.
- Full buffer with simultaneous push attempt and pop → push dropped, assertion fires, count=1 next cycle, alu_ready_o=1.
- Steady stream: push every cycle with wb_ready_i=1 → throughput 1/cycle, count stays 1, IDs 0..7 emerge in order, pointers wrap correctly.
- Two entries buffered, flush_i asserted together with alu_valid_i → next cycle count=0, wb_valid_o=0, flushed push never appears.
- Assert rst_ni=0 asynchronously mid-cycle with 2 entries buffered → wb_valid_o=0 immediately, alu_ready_o=1, all outputs 0.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Result FIFO between the combinational ALU and the shared writeback port.
// Absorbs writeback stalls and cuts the ALU-to-scoreboard timing path.
module alu_wb_buffer #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [XLEN-1:0]            alu_result_i,
    input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_wb_buffer: DEPTH must be a power of two and at least 2");
    end

    logic [XLEN-1:0]          result_q [DEPTH];
    logic [TRANS_ID_BITS-1:0] trans_id_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     push, pop;

    // Handshakes depend only on registered occupancy; flush masks both.
    assign alu_ready_o = (count_q < CNT_W'(DEPTH));
    assign wb_valid_o  = (count_q != '0);
    assign push        = alu_valid_i && alu_ready_o && !flush_i;
    assign pop         = wb_valid_o && wb_ready_i && !flush_i;
    assign count_o     = count_q;

    assign wb_result_o   = wb_valid_o ? result_q[rd_ptr_q]   : '0;
    assign wb_trans_id_o = wb_valid_o ? trans_id_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy gates what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            result_q[wr_ptr_q]   <= alu_result_i;
            trans_id_q[wr_ptr_q] <= alu_trans_id_i;
        end
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(DEPTH));

    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (count_q != '0));

    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_valid_o && !wb_ready_i && !flush_i) |=>
        (wb_valid_o && $stable(wb_result_o) && $stable(wb_trans_id_o)));

    a_upstream_overrun : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alu_valid_i && !flush_i) |-> alu_ready_o)
        else $warning("alu_wb_buffer: ALU result dropped, buffer was full");
`endif

endmodule
